core_dispatch_scoreboard: RTL and testbench
===========================================

Name: core_dispatch_scoreboard

Overview:
- Pending-write scoreboard for the dual-issue dispatch stage.
- Records destination registers of instructions the hazard logic has just dispatched, and retires them on execution-unit completion.
- Produces per-EU in-flight write masks, structural-busy flags, `branch_stall` and `wb_stall_branch`, which feed back into the dispatch hazard check.

Parameters:
- NREGS, 16: architectural registers; mask width (hword).
- ALU_LAT, 2: cycles from ALU dispatch to writeback; ≥1.
- BRANCH_LAT, 2: cycles from branch dispatch to link writeback; ≥1.
- MUL_LAT, 4: cycles from multiplier dispatch to writeback; ≥1 and ≠ BRANCH_LAT; elaboration error otherwise.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- dispatch_a / dispatch_b  in  1  slot A/B instruction accepted this cycle
- unit_a / unit_b  in  eu_sel  target EU of slot A/B (EU_ALU, EU_MUL, EU_LDST, EU_BRANCH)
- wb_a / wb_b  in  1  slot A/B writes a register
- rd_a / rd_b  in  reg_num  destination of slot A/B
- ldst_done  in  1  load/store unit writeback pulse
- mask_alu_a / mask_alu_b / mask_branch / mask_mul / mask_ldst  out  NREGS  registers with pending write per EU
- mul_busy / ldst_busy  out  1  EU occupied
- branch_stall  out  1  branch in flight
- wb_stall_branch  out  1  a branch dispatched now would collide with multiplier writeback

Behaviour:
- Reset, async: all shift stages, counters and masks clear. Every output is 0 while rst is high and in the first cycle after release.
- Enable: an entry is recorded only if dispatch_x && wb_x. Its bit is onehot(rd_x). Dispatch without wb_x sets no mask bit but still occupies the EU.
- Slot A on EU_ALU feeds chain A; slot B on EU_ALU feeds chain B.
- EU_MUL, EU_LDST and EU_BRANCH are shared by both slots; the upstream check guarantees at most one per cycle.
- ALU/branch chains: each is a LAT-deep shift register of masks; the mask output is the OR of all stages.
  - Dispatch at cycle t: bit visible in cycles t+1..t+LAT, clear at t+LAT+1.
  - Independent entries on consecutive cycles overlap correctly.
- branch_stall = any branch stage valid, including non-writeback branches. It is the OR of a per-stage valid chain that runs in parallel.
- Multiplier:
  - Down-counter loaded with MUL_LAT on dispatch and decremented when nonzero.
  - mul_busy and mask_mul hold while count ≠ 0; both clear the cycle after count reaches 0.
  - Dispatch while mul_busy is a protocol violation: simulation assertion fires; the new request overwrites the old one.
- wb_stall_branch = (mul count == BRANCH_LAT+1). Registered state only; no combinational path from dispatch inputs.
- Load/store:
  - Dispatch sets ldst_busy and mask_ldst = onehot(rd) (or 0 if !wb); both hold until ldst_done.
  - ldst_done without busy is ignored.
  - ldst_done and a new ldst dispatch in the same cycle: the old entry retires, the new one is installed, busy stays 1.
- WAW: the same rd may be set in several EU masks simultaneously. Each clears independently; there is no cross-EU clearing.
- Slot A and slot B with the same rd in one cycle: both recorded.
- Reset mid-operation discards all in-flight entries. No writeback notification is produced.

Decomposition:
- Shared core uarch package holds eu_sel enum, reg_num, hword and NREGS.
- One sub-module, core_dispatch_scoreboard_chain: parameterized LAT-deep mask+valid shift register with OR reduction. Instantiated three times (ALU A, ALU B, branch).
- Multiplier counter and ldst holding register stay inline.

Test Plan:
- Reset: assert rst mid-run with mul count 3 and ldst pending -> all outputs 0 immediately, and still 0 one cycle after release.
- ALU A dispatch rd=5 at t0 -> mask_alu_a=0x0020 in t0+1 and t0+2, 0x0000 at t0+3; mask_alu_b stays 0.
- Dual ALU dispatch rd_a=3, rd_b=3 -> both masks 0x0008 for 2 cycles. Dispatch with wb=0 -> masks stay 0.
- MUL rd=7 at t0 -> mul_busy and mask_mul=0x0080 for t0+1..t0+4; wb_stall_branch high only in t0+2 (count==3).
- LDST rd=2, ldst_done 6 cycles later coincident with new ldst rd=9 -> mask_ldst 0x0004 then 0x0200 with no gap; ldst_busy continuously 1.
- Branch without writeback at t0 -> branch_stall high t0+1..t0+2, mask_branch 0. Second mul dispatch while busy -> assertion fires.

Source files
------------

// File: rtl/core_dispatch_scoreboard_pkg.sv
// rtl/core_dispatch_scoreboard_pkg.sv - shared dispatch-stage types for the pending-write scoreboard
package core_dispatch_scoreboard_pkg;

  localparam int NREGS = 16;
  localparam int REG_W = $clog2(NREGS);

  typedef logic [NREGS-1:0] hword;
  typedef logic [REG_W-1:0] reg_num;

  typedef enum logic [1:0] {
    EU_ALU    = 2'd0,
    EU_MUL    = 2'd1,
    EU_LDST   = 2'd2,
    EU_BRANCH = 2'd3
  } eu_sel;

  function automatic hword onehot(input reg_num r);
    hword v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/core_dispatch_scoreboard_chain.sv
// rtl/core_dispatch_scoreboard_chain.sv - LAT-deep mask+valid shift register with OR reduction
module core_dispatch_scoreboard_chain
  import core_dispatch_scoreboard_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  hword i_mask,
  output hword o_mask,
  output logic o_valid
);

  hword           r_mask [LAT];
  logic [LAT-1:0] r_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < LAT; i++) r_mask[i] <= '0;
      r_valid <= '0;
    end else begin
      r_mask[0]  <= i_mask;
      r_valid[0] <= i_push;
      for (int i = 1; i < LAT; i++) begin
        r_mask[i]  <= r_mask[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  always_comb begin
    o_mask = '0;
    for (int i = 0; i < LAT; i++) o_mask = o_mask | r_mask[i];
  end

  assign o_valid = |r_valid;

endmodule

// File: rtl/core_dispatch_scoreboard.sv
// rtl/core_dispatch_scoreboard.sv - pending-write scoreboard for the dual-issue dispatch stage
module core_dispatch_scoreboard
  import core_dispatch_scoreboard_pkg::*;
#(
  parameter int ALU_LAT    = 2,
  parameter int BRANCH_LAT = 2,
  parameter int MUL_LAT    = 4
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_dispatch_a,
  input  logic   i_dispatch_b,
  input  eu_sel  i_unit_a,
  input  eu_sel  i_unit_b,
  input  logic   i_wb_a,
  input  logic   i_wb_b,
  input  reg_num i_rd_a,
  input  reg_num i_rd_b,
  input  logic   i_ldst_done,
  output hword   o_mask_alu_a,
  output hword   o_mask_alu_b,
  output hword   o_mask_branch,
  output hword   o_mask_mul,
  output hword   o_mask_ldst,
  output logic   o_mul_busy,
  output logic   o_ldst_busy,
  output logic   o_branch_stall,
  output logic   o_wb_stall_branch
);

  localparam int CNT_W     = $clog2(MUL_LAT + 1);
  localparam int STALL_CNT = BRANCH_LAT + 1;

  generate
    if (ALU_LAT < 1 || BRANCH_LAT < 1 || MUL_LAT < 1 || MUL_LAT == BRANCH_LAT) begin : g_bad_params
      $error("core_dispatch_scoreboard: latencies must be >= 1 and MUL_LAT != BRANCH_LAT");
    end
  endgenerate

  // Per-slot record mask; a dispatch without writeback still occupies its EU.
  hword w_rec_a, w_rec_b;
  assign w_rec_a = i_wb_a ? onehot(i_rd_a) : '0;
  assign w_rec_b = i_wb_b ? onehot(i_rd_b) : '0;

  logic w_alu_a_push, w_alu_b_push;
  logic w_br_a, w_br_b, w_br_push;
  logic w_mul_a, w_mul_b, w_mul_push;
  logic w_ldst_a, w_ldst_b, w_ldst_push;
  hword w_br_mask, w_mul_mask, w_ldst_mask;

  assign w_alu_a_push = i_dispatch_a && (i_unit_a == EU_ALU);
  assign w_alu_b_push = i_dispatch_b && (i_unit_b == EU_ALU);
  assign w_br_a       = i_dispatch_a && (i_unit_a == EU_BRANCH);
  assign w_br_b       = i_dispatch_b && (i_unit_b == EU_BRANCH);
  assign w_mul_a      = i_dispatch_a && (i_unit_a == EU_MUL);
  assign w_mul_b      = i_dispatch_b && (i_unit_b == EU_MUL);
  assign w_ldst_a     = i_dispatch_a && (i_unit_a == EU_LDST);
  assign w_ldst_b     = i_dispatch_b && (i_unit_b == EU_LDST);

  assign w_br_push   = w_br_a | w_br_b;
  assign w_mul_push  = w_mul_a | w_mul_b;
  assign w_ldst_push = w_ldst_a | w_ldst_b;

  assign w_br_mask   = (w_br_a ? w_rec_a : '0) | (w_br_b ? w_rec_b : '0);
  assign w_mul_mask  = (w_mul_a ? w_rec_a : '0) | (w_mul_b ? w_rec_b : '0);
  assign w_ldst_mask = (w_ldst_a ? w_rec_a : '0) | (w_ldst_b ? w_rec_b : '0);

  hword w_alu_a_mask, w_alu_b_mask, w_br_chain_mask;
  logic w_alu_a_valid, w_alu_b_valid, w_br_valid;

  core_dispatch_scoreboard_chain #(.LAT(ALU_LAT)) u_chain_alu_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_alu_a_push),
    .i_mask  (w_alu_a_push ? w_rec_a : '0),
    .o_mask  (w_alu_a_mask),
    .o_valid (w_alu_a_valid)
  );

  core_dispatch_scoreboard_chain #(.LAT(ALU_LAT)) u_chain_alu_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_alu_b_push),
    .i_mask  (w_alu_b_push ? w_rec_b : '0),
    .o_mask  (w_alu_b_mask),
    .o_valid (w_alu_b_valid)
  );

  core_dispatch_scoreboard_chain #(.LAT(BRANCH_LAT)) u_chain_branch (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_br_push),
    .i_mask  (w_br_mask),
    .o_mask  (w_br_chain_mask),
    .o_valid (w_br_valid)
  );

  assign o_mask_alu_a   = w_alu_a_valid ? w_alu_a_mask : '0;
  assign o_mask_alu_b   = w_alu_b_valid ? w_alu_b_mask : '0;
  assign o_mask_branch  = w_br_valid ? w_br_chain_mask : '0;
  assign o_branch_stall = w_br_valid;

  logic [CNT_W-1:0] r_mul_cnt;
  hword             r_mul_mask;
  logic             w_mul_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mul_cnt  <= '0;
      r_mul_mask <= '0;
    end else if (w_mul_push) begin
      r_mul_cnt  <= CNT_W'(MUL_LAT);
      r_mul_mask <= w_mul_mask;
    end else if (r_mul_cnt != '0) begin
      r_mul_cnt <= r_mul_cnt - CNT_W'(1);
    end
  end

  assign w_mul_busy = (r_mul_cnt != '0);
  assign o_mul_busy = w_mul_busy;
  assign o_mask_mul = w_mul_busy ? r_mul_mask : '0;

  // Branch dispatched now would write back exactly when the multiplier does.
  assign o_wb_stall_branch = (int'(r_mul_cnt) == STALL_CNT);

  a_mul_overlap : assert property (@(posedge i_clk) disable iff (i_rst) !(w_mul_push && w_mul_busy))
    else $error("core_dispatch_scoreboard: multiplier dispatched while busy");

  logic r_ldst_busy;
  hword r_ldst_mask;

  // A new dispatch wins over a coincident done, so the handover has no gap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ldst_busy <= 1'b0;
      r_ldst_mask <= '0;
    end else if (w_ldst_push) begin
      r_ldst_busy <= 1'b1;
      r_ldst_mask <= w_ldst_mask;
    end else if (i_ldst_done) begin
      r_ldst_busy <= 1'b0;
      r_ldst_mask <= '0;
    end
  end

  assign o_ldst_busy = r_ldst_busy;
  assign o_mask_ldst = r_ldst_mask;

endmodule

// File: tb/tb_core_dispatch_scoreboard.sv
// tb/tb_core_dispatch_scoreboard.sv - self-checking bench for the dispatch scoreboard
module tb_core_dispatch_scoreboard;
  import core_dispatch_scoreboard_pkg::*;

  localparam int ALU_LAT    = 2;
  localparam int BRANCH_LAT = 2;
  localparam int MUL_LAT    = 4;
  localparam int HMAX       = 4096;

  logic   clk = 1'b0;
  logic   i_rst = 1'b0;
  logic   i_dispatch_a = 1'b0, i_dispatch_b = 1'b0;
  eu_sel  i_unit_a = EU_ALU, i_unit_b = EU_ALU;
  logic   i_wb_a = 1'b0, i_wb_b = 1'b0;
  reg_num i_rd_a = '0, i_rd_b = '0;
  logic   i_ldst_done = 1'b0;
  hword   o_mask_alu_a, o_mask_alu_b, o_mask_branch, o_mask_mul, o_mask_ldst;
  logic   o_mul_busy, o_ldst_busy, o_branch_stall, o_wb_stall_branch;

  always #5 clk = ~clk;

  core_dispatch_scoreboard #(
    .ALU_LAT(ALU_LAT), .BRANCH_LAT(BRANCH_LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_dispatch_a(i_dispatch_a), .i_dispatch_b(i_dispatch_b),
    .i_unit_a(i_unit_a), .i_unit_b(i_unit_b),
    .i_wb_a(i_wb_a), .i_wb_b(i_wb_b),
    .i_rd_a(i_rd_a), .i_rd_b(i_rd_b),
    .i_ldst_done(i_ldst_done),
    .o_mask_alu_a(o_mask_alu_a), .o_mask_alu_b(o_mask_alu_b),
    .o_mask_branch(o_mask_branch), .o_mask_mul(o_mask_mul), .o_mask_ldst(o_mask_ldst),
    .o_mul_busy(o_mul_busy), .o_ldst_busy(o_ldst_busy),
    .o_branch_stall(o_branch_stall), .o_wb_stall_branch(o_wb_stall_branch)
  );

  wire [5*NREGS+3:0] w_all = {o_mask_alu_a, o_mask_alu_b, o_mask_branch, o_mask_mul, o_mask_ldst,
                              o_mul_busy, o_ldst_busy, o_branch_stall, o_wb_stall_branch};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int epoch = 0;

  // Reference history: what was dispatched in each cycle, plus the ldst state expected per cycle.
  bit [NREGS-1:0] h_mask [3][HMAX];
  bit             h_val  [3][HMAX];
  bit             h_ld_busy [HMAX];
  bit [NREGS-1:0] h_ld_mask [HMAX];
  int             mul_t = -1000;
  bit [NREGS-1:0] mul_m;

  function automatic bit [NREGS-1:0] exp_mask(input int w, input int c, input int lat);
    bit [NREGS-1:0] m = '0;
    for (int k = 1; k <= lat; k++)
      if (c - k >= epoch && c - k >= 0) m = m | h_mask[w][c-k];
    return m;
  endfunction

  function automatic bit exp_valid(input int w, input int c, input int lat);
    bit v = 1'b0;
    for (int k = 1; k <= lat; k++)
      if (c - k >= epoch && c - k >= 0) v = v | h_val[w][c-k];
    return v;
  endfunction

  function automatic int exp_mul_cnt(input int c);
    int d = c - mul_t;
    return (d >= 1 && d <= MUL_LAT) ? (MUL_LAT + 1 - d) : 0;
  endfunction

  task automatic drive(input bit da, input eu_sel ua, input bit wa, input int ra,
                       input bit db, input eu_sel ub, input bit wb, input int rb, input bit done);
    bit [NREGS-1:0] one, ma, mb;
    one = {{(NREGS-1){1'b0}}, 1'b1};
    i_dispatch_a = da; i_unit_a = ua; i_wb_a = wa; i_rd_a = reg_num'(ra);
    i_dispatch_b = db; i_unit_b = ub; i_wb_b = wb; i_rd_b = reg_num'(rb);
    i_ldst_done  = done;
    ma = wa ? (one << ra) : '0;
    mb = wb ? (one << rb) : '0;
    h_val[0][cyc]  = da && ua == EU_ALU;
    h_mask[0][cyc] = (da && ua == EU_ALU) ? ma : '0;
    h_val[1][cyc]  = db && ub == EU_ALU;
    h_mask[1][cyc] = (db && ub == EU_ALU) ? mb : '0;
    h_val[2][cyc]  = (da && ua == EU_BRANCH) || (db && ub == EU_BRANCH);
    h_mask[2][cyc] = ((da && ua == EU_BRANCH) ? ma : '0) | ((db && ub == EU_BRANCH) ? mb : '0);
    if (da && ua == EU_MUL) begin mul_t = cyc; mul_m = ma; end
    if (db && ub == EU_MUL) begin mul_t = cyc; mul_m = mb; end
    if (da && ua == EU_LDST) begin
      h_ld_busy[cyc+1] = 1'b1; h_ld_mask[cyc+1] = ma;
    end else if (db && ub == EU_LDST) begin
      h_ld_busy[cyc+1] = 1'b1; h_ld_mask[cyc+1] = mb;
    end else if (done) begin
      h_ld_busy[cyc+1] = 1'b0; h_ld_mask[cyc+1] = '0;
    end else begin
      h_ld_busy[cyc+1] = h_ld_busy[cyc]; h_ld_mask[cyc+1] = h_ld_mask[cyc];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input bit done);
    drive(1'b0, EU_ALU, 1'b0, 0, 1'b0, EU_ALU, 1'b0, 0, done);
    tick();
  endtask

  task automatic assert_rst();
    i_rst = 1'b1;
    i_dispatch_a = 1'b0; i_dispatch_b = 1'b0; i_ldst_done = 1'b0;
    #1;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    cyc++;
    i_rst = 1'b0;
    epoch = cyc;
    h_ld_busy[cyc] = 1'b0;
    h_ld_mask[cyc] = '0;
    mul_t = -1000;
  endtask

  task automatic test_reset();
    #1 i_rst = 1'b1;
    #1;
    n_cmp++;
    if (w_all !== '0) begin n_bad++; $display("FAIL reset_held got=%h want=0", w_all); end
    release_rst();
    n_cmp++;
    if (w_all !== '0) begin n_bad++; $display("FAIL reset_release got=%h want=0", w_all); end
    idle(1'b0);
    n_cmp++;
    if (w_all !== '0) begin n_bad++; $display("FAIL reset_after got=%h want=0", w_all); end
  endtask

  task automatic test_alu();
    bit [NREGS-1:0] want;
    drive(1'b1, EU_ALU, 1'b1, 5, 1'b0, EU_ALU, 1'b0, 0, 1'b0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      want = (k <= 2) ? 16'h0020 : 16'h0000;
      n_cmp++;
      if (o_mask_alu_a !== want) begin n_bad++; $display("FAIL alu_a t0+%0d got=%h want=%h", k, o_mask_alu_a, want); end
      n_cmp++;
      if (o_mask_alu_b !== '0) begin n_bad++; $display("FAIL alu_b_quiet t0+%0d got=%h want=0", k, o_mask_alu_b); end
      idle(1'b0);
    end
  endtask

  task automatic test_dual_alu();
    bit [NREGS-1:0] want;
    drive(1'b1, EU_ALU, 1'b1, 3, 1'b1, EU_ALU, 1'b1, 3, 1'b0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      want = (k <= 2) ? 16'h0008 : 16'h0000;
      n_cmp++;
      if (o_mask_alu_a !== want || o_mask_alu_b !== want) begin
        n_bad++; $display("FAIL dual_alu t0+%0d got=%h/%h want=%h", k, o_mask_alu_a, o_mask_alu_b, want);
      end
      idle(1'b0);
    end
    drive(1'b1, EU_ALU, 1'b0, 6, 1'b1, EU_ALU, 1'b0, 6, 1'b0);
    tick();
    for (int k = 1; k <= 2; k++) begin
      n_cmp++;
      if (o_mask_alu_a !== '0 || o_mask_alu_b !== '0) begin
        n_bad++; $display("FAIL alu_nowb t0+%0d got=%h/%h want=0", k, o_mask_alu_a, o_mask_alu_b);
      end
      idle(1'b0);
    end
  endtask

  task automatic test_mul();
    drive(1'b1, EU_MUL, 1'b1, 7, 1'b0, EU_ALU, 1'b0, 0, 1'b0);
    tick();
    for (int k = 1; k <= MUL_LAT + 1; k++) begin
      n_cmp++;
      if (o_mul_busy !== (k <= 4)) begin n_bad++; $display("FAIL mul_busy t0+%0d got=%b want=%b", k, o_mul_busy, k <= 4); end
      n_cmp++;
      if (o_mask_mul !== ((k <= 4) ? 16'h0080 : 16'h0000)) begin
        n_bad++; $display("FAIL mul_mask t0+%0d got=%h", k, o_mask_mul);
      end
      n_cmp++;
      if (o_wb_stall_branch !== (k == 2)) begin
        n_bad++; $display("FAIL wb_stall t0+%0d got=%b want=%b", k, o_wb_stall_branch, k == 2);
      end
      idle(1'b0);
    end
  endtask

  task automatic test_ldst();
    drive(1'b0, EU_ALU, 1'b0, 0, 1'b1, EU_LDST, 1'b1, 2, 1'b0);
    tick();
    for (int k = 1; k <= 6; k++) begin
      n_cmp++;
      if (o_ldst_busy !== 1'b1 || o_mask_ldst !== 16'h0004) begin
        n_bad++; $display("FAIL ldst_hold t0+%0d got=%b/%h want=1/0004", k, o_ldst_busy, o_mask_ldst);
      end
      if (k < 6) idle(1'b0);
    end
    drive(1'b1, EU_LDST, 1'b1, 9, 1'b0, EU_ALU, 1'b0, 0, 1'b1);
    tick();
    n_cmp++;
    if (o_ldst_busy !== 1'b1 || o_mask_ldst !== 16'h0200) begin
      n_bad++; $display("FAIL ldst_handover got=%b/%h want=1/0200", o_ldst_busy, o_mask_ldst);
    end
    idle(1'b1);
    n_cmp++;
    if (o_ldst_busy !== 1'b0 || o_mask_ldst !== '0) begin
      n_bad++; $display("FAIL ldst_retire got=%b/%h want=0/0000", o_ldst_busy, o_mask_ldst);
    end
    idle(1'b1);
    n_cmp++;
    if (o_ldst_busy !== 1'b0 || o_mask_ldst !== '0) begin
      n_bad++; $display("FAIL ldst_spurious_done got=%b/%h want=0/0000", o_ldst_busy, o_mask_ldst);
    end
  endtask

  task automatic test_branch();
    drive(1'b1, EU_BRANCH, 1'b0, 4, 1'b0, EU_ALU, 1'b0, 0, 1'b0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      n_cmp++;
      if (o_branch_stall !== (k <= 2) || o_mask_branch !== '0) begin
        n_bad++; $display("FAIL branch_nowb t0+%0d got=%b/%h want=%b/0000", k, o_branch_stall, o_mask_branch, k <= 2);
      end
      idle(1'b0);
    end
    drive(1'b0, EU_ALU, 1'b0, 0, 1'b1, EU_BRANCH, 1'b1, 12, 1'b0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      n_cmp++;
      if (o_mask_branch !== ((k <= 2) ? 16'h1000 : 16'h0000)) begin
        n_bad++; $display("FAIL branch_link t0+%0d got=%h", k, o_mask_branch);
      end
      idle(1'b0);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, EU_MUL, 1'b1, 7, 1'b1, EU_LDST, 1'b1, 2, 1'b0);
    tick();
    idle(1'b0);
    n_cmp++;
    if (o_mul_busy !== 1'b1 || o_ldst_busy !== 1'b1 || o_wb_stall_branch !== 1'b1) begin
      n_bad++; $display("FAIL midrst_setup got=%b%b%b want=111", o_mul_busy, o_ldst_busy, o_wb_stall_branch);
    end
    assert_rst();
    n_cmp++;
    if (w_all !== '0) begin n_bad++; $display("FAIL midrst_async got=%h want=0", w_all); end
    release_rst();
    n_cmp++;
    if (w_all !== '0) begin n_bad++; $display("FAIL midrst_release got=%h want=0", w_all); end
    idle(1'b0);
    n_cmp++;
    if (w_all !== '0) begin n_bad++; $display("FAIL midrst_after got=%h want=0", w_all); end
  endtask

  task automatic test_random();
    bit da, db, wa, wb, done;
    eu_sel ua, ub;
    int ra, rb;
    for (int n = 0; n < 800; n++) begin
      if (n == 400) begin
        assert_rst();
        release_rst();
      end
      da = ($urandom_range(0, 9) < 7);
      db = ($urandom_range(0, 9) < 7);
      ua = eu_sel'($urandom_range(0, 3));
      ub = eu_sel'($urandom_range(0, 3));
      wa = $urandom_range(0, 3) != 0;
      wb = $urandom_range(0, 3) != 0;
      ra = $urandom_range(0, NREGS - 1);
      rb = $urandom_range(0, NREGS - 1);
      done = ($urandom_range(0, 3) == 0);
      if (da && db && ua == ub && ua != EU_ALU) ub = EU_ALU;
      if (exp_mul_cnt(cyc) != 0) begin
        if (ua == EU_MUL) ua = EU_ALU;
        if (ub == EU_MUL) ub = EU_ALU;
      end
      drive(da, ua, wa, ra, db, ub, wb, rb, done);
      tick();
      n_cmp++;
      if (o_mask_alu_a !== exp_mask(0, cyc, ALU_LAT)) begin
        n_bad++; $display("FAIL rnd_alu_a cyc=%0d got=%h want=%h", cyc, o_mask_alu_a, exp_mask(0, cyc, ALU_LAT));
      end
      n_cmp++;
      if (o_mask_alu_b !== exp_mask(1, cyc, ALU_LAT)) begin
        n_bad++; $display("FAIL rnd_alu_b cyc=%0d got=%h want=%h", cyc, o_mask_alu_b, exp_mask(1, cyc, ALU_LAT));
      end
      n_cmp++;
      if (o_mask_branch !== exp_mask(2, cyc, BRANCH_LAT)) begin
        n_bad++; $display("FAIL rnd_br_mask cyc=%0d got=%h want=%h", cyc, o_mask_branch, exp_mask(2, cyc, BRANCH_LAT));
      end
      n_cmp++;
      if (o_branch_stall !== exp_valid(2, cyc, BRANCH_LAT)) begin
        n_bad++; $display("FAIL rnd_br_stall cyc=%0d got=%b want=%b", cyc, o_branch_stall, exp_valid(2, cyc, BRANCH_LAT));
      end
      n_cmp++;
      if (o_mul_busy !== (exp_mul_cnt(cyc) != 0)) begin
        n_bad++; $display("FAIL rnd_mul_busy cyc=%0d got=%b want=%b", cyc, o_mul_busy, exp_mul_cnt(cyc) != 0);
      end
      n_cmp++;
      if (o_mask_mul !== ((exp_mul_cnt(cyc) != 0) ? mul_m : '0)) begin
        n_bad++; $display("FAIL rnd_mul_mask cyc=%0d got=%h want=%h", cyc, o_mask_mul, (exp_mul_cnt(cyc) != 0) ? mul_m : '0);
      end
      n_cmp++;
      if (o_wb_stall_branch !== (exp_mul_cnt(cyc) == BRANCH_LAT + 1)) begin
        n_bad++; $display("FAIL rnd_wb_stall cyc=%0d got=%b want=%b", cyc, o_wb_stall_branch, exp_mul_cnt(cyc) == BRANCH_LAT + 1);
      end
      n_cmp++;
      if (o_ldst_busy !== h_ld_busy[cyc] || o_mask_ldst !== h_ld_mask[cyc]) begin
        n_bad++; $display("FAIL rnd_ldst cyc=%0d got=%b/%h want=%b/%h", cyc, o_ldst_busy, o_mask_ldst, h_ld_busy[cyc], h_ld_mask[cyc]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_dual_alu();
    test_mul();
    test_ldst();
    test_branch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
